div_restoring_r2: RTL and testbench



---
 rtl/div_restoring_r2_pkg.sv | 6 +
 rtl/div_restoring_r2_if.sv | 14 +
 rtl/div_restoring_r2.sv | 65 ++++++
 tb/tb_div_restoring_r2.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/div_restoring_r2_pkg.sv
// div_restoring_r2_pkg: shared width, counter size and FSM encoding for the restoring divider
package div_restoring_r2_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
endpackage

// File: rtl/div_restoring_r2_if.sv
// div_restoring_r2_if: divide request/response handshake between ALU (master) and divide core (slave)
interface div_restoring_r2_if;
  import div_restoring_r2_pkg::*;
  logic enable;
  logic sign_en;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] quo_o;
  logic [DATA_W-1:0] rem_o;
  logic ready;
  logic complete;
  modport master(output enable, sign_en, op1, op2, input quo_o, rem_o, ready, complete);
  modport slave(input enable, sign_en, op1, op2, output quo_o, rem_o, ready, complete);
endinterface

// File: rtl/div_restoring_r2.sv
// div_restoring_r2: fixed 33-cycle radix-2 restoring divider on magnitudes, sign fixed up in a final cycle
module div_restoring_r2
  import div_restoring_r2_pkg::*;
(
  input logic clk,
  input logic rst,
  div_restoring_r2_if.slave bus
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_div, r_quo, r_rem;
  logic [2*DATA_W-1:0] r_acc;
  logic r_neg_q, r_neg_r, r_div0, r_complete;
  logic w_accept, w_last;
  logic [DATA_W:0] w_trial;
  function automatic logic [DATA_W-1:0] cneg(input logic [DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
  assign w_accept = (r_state == IDLE) && bus.enable;
  assign w_last = r_cnt == CNT_W'(DATA_W - 1);
  // shifted partial remainder needs 33 bits; a set MSB after subtracting means restore
  assign w_trial = r_acc[2*DATA_W-1:DATA_W-1] - {1'b0, r_div};
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (bus.enable ? ITER : IDLE) :
             (r_state == ITER) ? (w_last ? FIX : ITER) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_div <= '0;
      r_acc <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0 <= 1'b0;
      r_complete <= 1'b0;
    end else begin
      r_complete <= r_state == FIX;
      if (w_accept) begin
        r_div <= cneg(bus.op2, bus.sign_en & bus.op2[DATA_W-1]);
        r_acc <= {{DATA_W{1'b0}}, cneg(bus.op1, bus.sign_en & bus.op1[DATA_W-1])};
        r_neg_q <= bus.sign_en & (bus.op1[DATA_W-1] ^ bus.op2[DATA_W-1]);
        r_neg_r <= bus.sign_en & bus.op1[DATA_W-1];
        r_div0 <= bus.op2 == '0;
        r_cnt <= '0;
      end else if (r_state == ITER) begin
        r_acc <= w_trial[DATA_W] ? {r_acc[2*DATA_W-2:0], 1'b0}
                                 : {w_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == FIX) begin
        r_quo <= r_div0 ? '1 : cneg(r_acc[DATA_W-1:0], r_neg_q);
        r_rem <= cneg(r_acc[2*DATA_W-1:DATA_W], r_neg_r);
      end
    end
  end
  assign bus.ready = r_state == IDLE;
  assign bus.complete = r_complete;
  assign bus.quo_o = r_quo;
  assign bus.rem_o = r_rem;
endmodule

// File: tb/tb_div_restoring_r2.sv
// tb_div_restoring_r2: directed divides with a scoreboard queue checked by an independent completion monitor
module tb_div_restoring_r2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int low_cnt = 0;
  logic prev_complete = 1'b0;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int acc;
    string name;
  } exp_t;
  exp_t sb[$];
  div_restoring_r2_if bus();
  div_restoring_r2 dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      low_cnt = 0;
      prev_complete = 1'b0;
    end else begin
      if (bus.complete) begin
        exp_t e;
        chk("complete_single_cycle", {31'b0, prev_complete}, 32'd0);
        if (sb.size() == 0) chk("unexpected_complete", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk({e.name, "_quo"}, bus.quo_o, e.q);
          chk({e.name, "_rem"}, bus.rem_o, e.r);
          chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'd33);
          chk({e.name, "_ready_low"}, 32'(low_cnt), 32'd33);
          chk({e.name, "_ready_hi"}, {31'b0, bus.ready}, 32'd1);
        end
      end
      low_cnt = bus.ready ? 0 : low_cnt + 1;
      prev_complete = bus.complete;
    end
  end
  task automatic push(input string name, input logic [31:0] q, input logic [31:0] r);
    exp_t e;
    e.q = q;
    e.r = r;
    e.acc = cyc + 1;
    e.name = name;
    sb.push_back(e);
  endtask
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask
  task automatic issue(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r);
    wait_ready();
    bus.enable = 1'b1;
    bus.sign_en = s;
    bus.op1 = a;
    bus.op2 = b;
    push(name, q, r);
    @(negedge clk);
    bus.enable = 1'b0;
    bus.op1 = $urandom;
    bus.op2 = $urandom;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.sign_en = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, bus.ready}, 32'd1);
    chk("reset_complete", {31'b0, bus.complete}, 32'd0);
    chk("reset_quo", bus.quo_o, 32'd0);
    chk("reset_rem", bus.rem_o, 32'd0);
    rst = 1'b0;
    issue("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    drain();
    issue("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    drain();
    issue("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1);
    drain();
    issue("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    drain();
    issue("u_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    drain();
    issue("u_div0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
    drain();
    issue("s_div0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);
    drain();
    issue("s_zero_5", 1'b1, 32'd0, 32'd5, 32'd0, 32'd0);
    drain();
    issue("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    drain();
    wait_ready();
    bus.enable = 1'b1;
    bus.sign_en = 1'b0;
    bus.op1 = 32'd1000;
    bus.op2 = 32'd10;
    push("b2b_a", 32'd100, 32'd0);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.ready && n < 200) begin
        bus.op1 = $urandom;
        bus.op2 = $urandom | 32'd1;
        bus.sign_en = ~bus.sign_en;
        @(negedge clk);
        n++;
      end
      if (!bus.ready) chk("b2b_timeout", 32'd0, 32'd1);
    end
    bus.sign_en = 1'b1;
    bus.op1 = 32'hFFFFFF9C;
    bus.op2 = 32'd7;
    push("b2b_b", 32'hFFFFFFF2, 32'hFFFFFFFE);
    @(negedge clk);
    bus.enable = 1'b0;
    drain();
    wait_ready();
    bus.enable = 1'b1;
    bus.sign_en = 1'b0;
    bus.op1 = 32'd100;
    bus.op2 = 32'd7;
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'b0, bus.ready}, 32'd1);
    chk("abort_quo", bus.quo_o, 32'd0);
    chk("abort_rem", bus.rem_o, 32'd0);
    chk("abort_complete", {31'b0, bus.complete}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue("post_rst_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    drain();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
